// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch, decode and immediate-generator blocks.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// clear has priority over push and pop; push with pop at full is allowed.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !clear && (!full || pop);
        do_pop   = pop && !clear && !empty;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues word addresses to IMEM, buffers {inst, pc} and hands them to decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module inst_fetch_queue
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         pending_q, pending_d;
    logic [31:0]  pending_pc_q, pending_pc_d;

    logic         issue;
    logic         push, pop, clear;
    logic         fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t wr_entry, head_entry;

    // A slot is reserved for every outstanding read so a returning word always fits.
    always_comb begin
        issue        = !redirect_valid && !fifo_full &&
                       (int'(fifo_count) + int'(pending_q) + 1 <= DEPTH);
        fetch_pc_d   = fetch_pc_q;
        pending_d    = issue;
        pending_pc_d = pending_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
        end else if (issue) begin
            fetch_pc_d   = fetch_pc_q + 32'd4;
            pending_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    assign imem_en   = issue && rst_n;
    assign imem_addr = fetch_pc_q;

    // A redirect discards the in-flight word and everything queued, and blocks the pop.
    assign clear         = redirect_valid;
    assign push          = pending_q && !redirect_valid;
    assign pop           = dec_valid && dec_ready && !redirect_valid;
    assign wr_entry.inst = imem_rdata;
    assign wr_entry.pc   = pending_pc_q;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata (wr_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign dec_valid = !fifo_empty;
    assign dec_inst  = dec_valid ? head_entry.inst : INST_NOP;
    assign dec_pc    = dec_valid ? head_entry.pc   : 32'd0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push)                    perf_fetched_q <= perf_fetched_q + 32'd1;
            if (dec_ready && !dec_valid) perf_stall_q   <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: stimulus table, directed redirect/wrap/reset sequences and
// a randomized run against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic        m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_pc;
  int          m_fetched;
  int          m_stall;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[15];

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] x;
    x = a ^ (a >> 13);
    return x * 32'h9E37_79B1;
  endfunction

  // synchronous instruction memory: data one cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    imem_rdata <= imem_en ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle, compare against the model, then advance the model past the edge
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        e_en, e_v;
    logic [31:0] e_pc, e_inst;
    int          occ;
    @(negedge clk);
    dec_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    occ    = exp_q.size() + (m_inflight ? 1 : 0);
    e_en   = !rv && (occ + 1 <= DEPTH);
    e_v    = exp_q.size() > 0;
    e_pc   = e_v ? exp_q[0] : 32'd0;
    e_inst = e_v ? mem_word(exp_q[0]) : NOP;
    chk("model imem_en", {31'd0, imem_en}, {31'd0, e_en});
    chk("model imem_addr", imem_addr, m_pc);
    chk("model dec_valid", {31'd0, dec_valid}, {31'd0, e_v});
    chk("model dec_pc", dec_pc, e_pc);
    chk("model dec_inst", dec_inst, e_inst);
    if (rdy && !e_v) m_stall++;
    if (rv) begin
      exp_q.delete();
      m_inflight = 1'b0;
      m_pc       = rpc & ~32'd3;
    end else begin
      if (e_v && rdy) void'(exp_q.pop_front());
      if (m_inflight) begin
        exp_q.push_back(m_inflight_pc);
        m_fetched++;
      end
      m_inflight    = e_en;
      m_inflight_pc = m_pc;
      if (e_en) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("reset imem_en", {31'd0, imem_en}, 32'd0);
    chk("reset dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("reset dec_inst", dec_inst, NOP);
    chk("reset dec_pc", dec_pc, 32'd0);
    exp_q.delete();
    m_inflight    = 1'b0;
    m_inflight_pc = '0;
    m_pc          = RESET_PC;
    m_fetched     = 0;
    m_stall       = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'd0, 1'b1, RESET_PC,        1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'd0, 1'b1, RESET_PC + 4,    1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'd0, 1'b1, RESET_PC + 8,    1'b1, RESET_PC};
    vecs[3]  = '{1'b0, 1'b0, 32'd0, 1'b1, RESET_PC + 12,   1'b1, RESET_PC};
    for (int i = 4; i < 10; i++)
      vecs[i] = '{1'b0, 1'b0, 32'd0, 1'b0, RESET_PC + 16, 1'b1, RESET_PC};
    vecs[10] = '{1'b1, 1'b0, 32'd0, 1'b0, RESET_PC + 16,   1'b1, RESET_PC};
    vecs[11] = '{1'b1, 1'b0, 32'd0, 1'b1, RESET_PC + 16,   1'b1, RESET_PC + 4};
    vecs[12] = '{1'b1, 1'b0, 32'd0, 1'b1, RESET_PC + 20,   1'b1, RESET_PC + 8};
    vecs[13] = '{1'b1, 1'b0, 32'd0, 1'b1, RESET_PC + 24,   1'b1, RESET_PC + 12};
    vecs[14] = '{1'b1, 1'b0, 32'd0, 1'b1, RESET_PC + 28,   1'b1, RESET_PC + 16};

    // streaming from reset with decode always ready: no bubbles once primed
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'd0);
      chk("stream addr", imem_addr, RESET_PC + 32'(4 * i));
      if (i >= 2) begin
        chk("stream valid", {31'd0, dec_valid}, 32'd1);
        chk("stream pc", dec_pc, RESET_PC + 32'(4 * (i - 2)));
      end
    end

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("perf fetched early", perf_fetched, 32'd1);
    chk("perf stall early", perf_stall, 32'd2);
`endif

    // backpressure table: fill to DEPTH, hold head, then drain in order
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      chk($sformatf("vec%0d imem_en", i), {31'd0, imem_en}, {31'd0, vecs[i].exp_en});
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d dec_valid", i), {31'd0, dec_valid}, {31'd0, vecs[i].exp_v});
      chk($sformatf("vec%0d dec_pc", i), dec_pc, vecs[i].exp_pc);
    end

    // redirect with a pending response and decode ready
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h1000_0012);
    chk("redir N imem_en", {31'd0, imem_en}, 32'd0);
    chk("redir N head pc", dec_pc, RESET_PC);
    step(1'b1, 1'b0, 32'd0);
    chk("redir N+1 valid", {31'd0, dec_valid}, 32'd0);
    chk("redir N+1 imem_en", {31'd0, imem_en}, 32'd1);
    chk("redir N+1 addr", imem_addr, 32'h1000_0010);
    step(1'b1, 1'b0, 32'd0);
    chk("redir N+2 valid", {31'd0, dec_valid}, 32'd0);
    chk("redir N+2 addr", imem_addr, 32'h1000_0014);
    step(1'b1, 1'b0, 32'd0);
    chk("redir N+3 valid", {31'd0, dec_valid}, 32'd1);
    chk("redir N+3 pc", dec_pc, 32'h1000_0010);
    chk("redir N+3 inst", dec_inst, mem_word(32'h1000_0010));

    // back-to-back redirects: only the latest target survives
    step(1'b1, 1'b1, 32'h2000_0000);
    step(1'b1, 1'b1, 32'h3000_0006);
    step(1'b1, 1'b0, 32'd0);
    chk("b2b N+1 addr", imem_addr, 32'h3000_0004);
    chk("b2b N+1 valid", {31'd0, dec_valid}, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("b2b N+3 pc", dec_pc, 32'h3000_0004);

    // address wrap, then reset in the middle of the stream
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'd0);
    chk("wrap addr0", imem_addr, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'd0);
    chk("wrap addr1", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0);
    chk("wrap addr2", imem_addr, 32'h0000_0000);
    chk("wrap head pc", dec_pc, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'd0);
    chk("wrap head pc2", dec_pc, 32'hFFFF_FFFC);
    do_reset();
    step(1'b1, 1'b0, 32'd0);
    chk("restart imem_en", {31'd0, imem_en}, 32'd1);
    chk("restart addr", imem_addr, RESET_PC);

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic        rdy, rv;
      logic [31:0] rpc;
      if ($urandom_range(0, 399) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 24) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      step(rdy, rv, rpc);
    end

`ifdef FETCH_PERF_CNT_EN
    step(1'b0, 1'b1, 32'h4000_0000);
    chk("perf fetched", perf_fetched, 32'(m_fetched));
    chk("perf stall", perf_stall, 32'(m_stall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
